// File: rtl/mem_stage_sequencer.sv
// mem_stage_sequencer: LC-3b MEM-stage controller sequencing one or two handshaked memory accesses per instruction.
// Optional MEM_TIMEOUT_EN adds a per-access wait limit (TIMEOUT_CYCLES) that aborts with mem_err.
module mem_stage_sequencer #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req_valid,
    input  logic [2:0]              op,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   store_data,
    input  logic                    mem_resp,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
    output logic                    stall,
    output logic                    done,
    output logic [DATA_WIDTH-1:0]   load_data,
    output logic                    mem_err
);
    localparam int LANES = DATA_WIDTH / 8;
    localparam int LB = $clog2(LANES);
    localparam logic [ADDR_WIDTH-1:0] AMASK = ~ADDR_WIDTH'(LANES - 1);
    localparam logic [2:0] OP_LDR = 3'd0, OP_STR = 3'd1, OP_LDB = 3'd2, OP_STB = 3'd3,
                           OP_LDI = 3'd4, OP_STI = 3'd5, OP_TRAP = 3'd6, OP_RSV = 3'd7;

    typedef enum logic [1:0] {IDLE, FIRST, INDIRECT, COMPLETE} state_t;

    state_t                state_q, state_d;
    logic [2:0]            op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] sdata_q, sdata_d, load_q, load_d;
    logic                  active, second, is_byte, is_store, timeout;
    logic [LB-1:0]         lane;
    logic [7:0]            rbyte;

    assign active   = (state_q == FIRST) || (state_q == INDIRECT);
    assign second   = state_q == INDIRECT;
    assign is_byte  = (op_q == OP_LDB) || (op_q == OP_STB);
    // STI's first access reads the pointer; only its second access writes
    assign is_store = second ? (op_q == OP_STI) : ((op_q == OP_STR) || (op_q == OP_STB));
    assign lane     = addr_q[LB-1:0];
    assign rbyte    = mem_rdata[8*lane +: 8];

    assign mem_read        = active & ~is_store;
    assign mem_write       = active & is_store;
    assign mem_address     = !active ? '0 : is_byte ? addr_q : ((second ? ptr_q : addr_q) & AMASK);
    assign mem_wdata       = !active ? '0 : is_byte ? {LANES{sdata_q[7:0]}} : sdata_q;
    assign mem_byte_enable = !active ? '0 : is_byte ? LANES'(1) << lane : {LANES{1'b1}};
    assign stall           = ((state_q == IDLE) && req_valid) || active;
    assign done            = state_q == COMPLETE;
    assign load_data       = load_q;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        sdata_d = sdata_q;
        ptr_d   = ptr_q;
        load_d  = load_q;
        case (state_q)
            IDLE: if (req_valid) begin
                if (op == OP_RSV) begin
                    state_d = COMPLETE;
                end else begin
                    state_d = FIRST;
                    op_d    = op;
                    addr_d  = addr;
                    sdata_d = store_data;
                end
            end
            FIRST: if (mem_resp) begin
                state_d = (op_q == OP_LDI || op_q == OP_STI) ? INDIRECT : COMPLETE;
                ptr_d   = (op_q == OP_LDI || op_q == OP_STI) ? ADDR_WIDTH'(mem_rdata) : ptr_q;
                load_d  = (op_q == OP_LDB) ? {{(DATA_WIDTH-8){rbyte[7]}}, rbyte} :
                          (op_q == OP_LDR || op_q == OP_TRAP) ? mem_rdata : load_q;
            end else if (timeout) begin
                state_d = COMPLETE;
            end
            INDIRECT: if (mem_resp) begin
                state_d = COMPLETE;
                load_d  = (op_q == OP_LDI) ? mem_rdata : load_q;
            end else if (timeout) begin
                state_d = COMPLETE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            sdata_q <= '0;
            ptr_q   <= '0;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            sdata_q <= sdata_d;
            ptr_q   <= ptr_d;
            load_q  <= load_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q;
    logic          err_q;

    assign timeout = cnt_q == CW'(TIMEOUT_CYCLES);
    assign mem_err = done & err_q;

    // any state change restarts the wait count, so each access gets a full budget
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= (state_d != state_q) ? '0 : cnt_q + 1'b1;
            err_q <= active & ~mem_resp & timeout;
        end
    end
`else
    assign timeout = 1'b0;
    assign mem_err = TIMEOUT_CYCLES < 0;
`endif
endmodule

// File: doc/mem_stage_sequencer.md
Name: mem_stage_sequencer

Overview:
Parametrised MEM-stage controller for the pipelined LC-3b datapath. It sequences one or two memory transactions per instruction: LDR, STR, LDB, STB, TRAP, and true indirect LDI/STI. It generates byte enables and lane steering for any power-of-two data width, and stalls the pipeline until the access completes. It replaces single-cycle mem_read/mem_write control-word bits with a handshaked multi-cycle sequence.

Parameters:
DATA_WIDTH, 16, memory/register data width in bits; power of two, at least 16.
ADDR_WIDTH, 16, memory address width in bits.
TIMEOUT_CYCLES, 255, maximum wait cycles per access; used only with MEM_TIMEOUT_EN.

Ports:
clk  input  1  clock; all state updates on its rising edge.
reset_n  input  1  asynchronous, active-low reset.
req_valid  input  1  MEM stage holds an instruction needing this block; sampled only in IDLE.
op  input  3  000 LDR, 001 STR, 010 LDB, 011 STB, 100 LDI, 101 STI, 110 TRAP, 111 reserved.
addr  input  ADDR_WIDTH  effective address from the address adder.
store_data  input  DATA_WIDTH  source register value for stores.
mem_resp  input  1  memory completes the current access this cycle.
mem_rdata  input  DATA_WIDTH  read data, valid when mem_resp=1.
mem_read  output  1  read request.
mem_write  output  1  write request.
mem_address  output  ADDR_WIDTH  access address.
mem_wdata  output  DATA_WIDTH  write data.
mem_byte_enable  output  DATA_WIDTH/8  per-lane write enable.
stall  output  1  freeze upstream pipeline stages.
done  output  1  single-cycle completion pulse.
load_data  output  DATA_WIDTH  registered load result.
mem_err  output  1  single-cycle timeout-abort pulse; tied 0 when MEM_TIMEOUT_EN is off.

Behaviour:
- Definitions: LANES = DATA_WIDTH/8; LB = log2(LANES); lane = addr[LB-1:0].
- States: IDLE, FIRST, INDIRECT, COMPLETE.
- Reset: state IDLE. All outputs 0, including load_data, mem_address and mem_byte_enable. Internal latches (op, addr, data, pointer) are cleared. Reset applied mid-access abandons the access immediately, with no done pulse.
- IDLE:
  - req_valid=1 and op≠111: latch op, addr and store_data, then go to FIRST.
  - req_valid=1 and op=111: go to COMPLETE without any memory access.
  - req_valid=0: stay in IDLE.
- FIRST:
  - Hold mem_read or mem_write, mem_address, mem_wdata and mem_byte_enable stable until mem_resp=1.
  - On mem_resp: LDI/STI latch mem_rdata as the pointer and go to INDIRECT; all other ops go to COMPLETE.
- INDIRECT: LDI reads, and STI writes, the word at the aligned pointer. On mem_resp, go to COMPLETE.
- COMPLETE: done=1 and stall=0 for exactly one cycle, then IDLE unconditionally. A back-to-back instruction is accepted in the following IDLE cycle.
- stall = (IDLE & req_valid) | FIRST | INDIRECT.
- Request strobes are deasserted the cycle after mem_resp.
- req_valid changes during FIRST or INDIRECT are ignored.
- Minimum latency with mem_resp in the first cycle of each access:
  - single-access op: 3 cycles (IDLE, FIRST, COMPLETE);
  - LDI/STI: 4 cycles.
- Word accesses (LDR, STR, LDI, STI, TRAP, and the LDI/STI first access):
  - mem_address = address with its low LB bits cleared;
  - mem_byte_enable = all ones;
  - mem_wdata = store_data.
- Byte accesses (LDB, STB):
  - mem_address = addr unmodified;
  - mem_byte_enable = one-hot at lane;
  - STB mem_wdata = store_data[7:0] replicated across all lanes.
- load_data, registered on the mem_resp cycle:
  - LDR, LDI (second access), TRAP: mem_rdata.
  - LDB: byte at lane, sign-extended to DATA_WIDTH.
  - Stores leave load_data unchanged.
  - load_data holds until the next load completes.
- mem_byte_enable is meaningful only with mem_write; drive it anyway for all accesses.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - A wait counter clears on every entry to FIRST or INDIRECT and increments each cycle without mem_resp.
  - When the counter reaches TIMEOUT_CYCLES, go to COMPLETE with mem_err=1 and done=1 in that COMPLETE cycle; load_data is unchanged.
  - If mem_resp arrives in the same cycle the limit is reached, the response wins and there is no error.
- Undefined: no counter is built, mem_err is constant 0, and the block waits indefinitely for mem_resp.

Test Plan:
- LDR, addr=0x3005, mem_resp on first FIRST cycle, rdata=0xBEEF -> mem_address=0x3004, byte_enable=2'b11; done at cycle 3; load_data=0xBEEF; stall high cycles 1-2.
- STB, addr=0x4001, store_data=0x12A7 -> mem_write=1, mem_address=0x4001, byte_enable=2'b10, wdata=0xA7A7.
- LDB, addr=0x5000, rdata=0x7F80 -> load_data=0xFF80. Repeat with addr=0x5001 -> load_data=0x007F.
- LDI, addr=0x6000: first rdata=0x7002, second rdata=0x1234, mem_resp delayed 2 cycles each -> second mem_address=0x7002; done at cycle 8; load_data=0x1234.
- STI, with reset_n pulsed low during INDIRECT -> all outputs 0 immediately, no done, no write issued. After release, a new LDR completes normally.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, LDR with mem_resp never asserted -> mem_err=1 and done=1 in the cycle after the counter reaches 4; load_data unchanged.
